// File: rtl/rd_readout_ctrl.sv
// rd_readout_ctrl
// Reads one radio-detector event buffer out to the processor stream after the
// WCD/SSD readout of the same buffer has finished. The selected buffer's
// full/busy flags are checked first. If a transfer is still in flight, the
// controller waits for it, up to a bounded time. The buffer is then streamed
// one word at a time from the RD event memory. The buffer-full flag is cleared
// afterwards with a held strobe.
//
// Ports
//   CLK, RST              clock, asynchronous active-high reset
//   START, BUF_RNUM       readout request and buffer number (taken only when idle)
//   ABORT                 stop the current readout (not honoured during clear/finish)
//   RD_BUF_FULL/BUSY      per-buffer status flags, already synchronous to CLK
//   RD_PAR_ERR            per-buffer parity-error flags
//   MEM_ADDR, MEM_EN      byte address {buf, word, 2'b00} and 1-cycle read enable
//   MEM_DATA              read data, MEM_LAT cycles after MEM_EN
//   OUT_DATA/VALID/READY/LAST  processor-side stream, one word outstanding
//   CLR_BUF, CLR_STROBE   buffer-full clear request, held CLR_HOLD cycles
//   BUSY, DONE            not idle / 1-cycle completion pulse
//   RESULT, PARITY_FLAG   0=OK 1=EMPTY 2=TIMEOUT 3=ABORT, parity flag of the buffer
module rd_readout_ctrl #(
    parameter int unsigned NWORDS   = 2048,
    parameter int unsigned MEM_LAT  = 1,
    parameter int unsigned BUSY_TMO = 4096,
    parameter int unsigned CLR_HOLD = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [1:0]  BUF_RNUM,
    input  logic        ABORT,
    input  logic [3:0]  RD_BUF_FULL,
    input  logic [3:0]  RD_BUF_BUSY,
    input  logic [3:0]  RD_PAR_ERR,
    output logic [14:0] MEM_ADDR,
    output logic        MEM_EN,
    input  logic [31:0] MEM_DATA,
    output logic [31:0] OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        OUT_LAST,
    output logic [1:0]  CLR_BUF,
    output logic        CLR_STROBE,
    output logic        BUSY,
    output logic        DONE,
    output logic [1:0]  RESULT,
    output logic        PARITY_FLAG
);

    localparam int unsigned TMO_W  = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;
    localparam int unsigned LAT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int unsigned HOLD_W = (CLR_HOLD > 1) ? $clog2(CLR_HOLD) : 1;

    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(BUSY_TMO - 1);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(MEM_LAT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CLR_HOLD - 1);
    localparam logic [10:0]       WORD_LAST = 11'(NWORDS - 1);

    localparam logic [1:0] RES_OK      = 2'd0;
    localparam logic [1:0] RES_EMPTY   = 2'd1;
    localparam logic [1:0] RES_TIMEOUT = 2'd2;
    localparam logic [1:0] RES_ABORT   = 2'd3;

    typedef enum logic [2:0] {
        StIdle, StCheck, StWait, StIssue, StLat, StOut, StClear, StFin
    } state_t;

    state_t            state;
    logic [1:0]        buf_sel;
    logic [10:0]       word_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    logic sel_full, sel_busy, sel_par, abort_now;

    assign sel_full = RD_BUF_FULL[buf_sel];
    assign sel_busy = RD_BUF_BUSY[buf_sel];
    assign sel_par  = RD_PAR_ERR[buf_sel];
    // Once the clear strobe has started it must run to completion.
    assign abort_now = ABORT && (state inside {StCheck, StWait, StIssue, StLat, StOut});

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= StIdle;
            buf_sel     <= 2'd0;
            word_cnt    <= 11'd0;
            tmo_cnt     <= '0;
            lat_cnt     <= '0;
            hold_cnt    <= '0;
            MEM_ADDR    <= 15'd0;
            MEM_EN      <= 1'b0;
            OUT_DATA    <= 32'd0;
            OUT_VALID   <= 1'b0;
            OUT_LAST    <= 1'b0;
            CLR_BUF     <= 2'd0;
            CLR_STROBE  <= 1'b0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            RESULT      <= 2'd0;
            PARITY_FLAG <= 1'b0;
        end else begin
            MEM_EN <= 1'b0;
            DONE   <= 1'b0;
            if (abort_now) begin
                // Any read still in the memory pipeline is simply never captured.
                OUT_VALID <= 1'b0;
                OUT_LAST  <= 1'b0;
                RESULT    <= RES_ABORT;
                DONE      <= 1'b1;
                state     <= StFin;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (START) begin
                            buf_sel     <= BUF_RNUM;
                            RESULT      <= RES_OK;
                            PARITY_FLAG <= 1'b0;
                            BUSY        <= 1'b1;
                            state       <= StCheck;
                        end
                    end
                    StCheck: begin
                        PARITY_FLAG <= sel_par;
                        if (sel_full) begin
                            word_cnt <= 11'd0;
                            MEM_ADDR <= {buf_sel, 11'd0, 2'b00};
                            MEM_EN   <= 1'b1;
                            state    <= StIssue;
                        end else if (sel_busy) begin
                            tmo_cnt <= '0;
                            state   <= StWait;
                        end else begin
                            RESULT <= RES_EMPTY;
                            DONE   <= 1'b1;
                            state  <= StFin;
                        end
                    end
                    StWait: begin
                        // FULL takes priority over the timeout in the same cycle.
                        if (sel_full) begin
                            word_cnt <= 11'd0;
                            MEM_ADDR <= {buf_sel, 11'd0, 2'b00};
                            MEM_EN   <= 1'b1;
                            state    <= StIssue;
                        end else if (!sel_busy) begin
                            RESULT <= RES_EMPTY;
                            DONE   <= 1'b1;
                            state  <= StFin;
                        end else if (tmo_cnt == TMO_LAST) begin
                            RESULT <= RES_TIMEOUT;
                            DONE   <= 1'b1;
                            state  <= StFin;
                        end else begin
                            tmo_cnt <= tmo_cnt + 1'b1;
                        end
                    end
                    StIssue: begin
                        // MEM_EN is high during this state; count latency from here.
                        lat_cnt <= '0;
                        state   <= StLat;
                    end
                    StLat: begin
                        if (lat_cnt == LAT_LAST) begin
                            OUT_DATA  <= MEM_DATA;
                            OUT_VALID <= 1'b1;
                            OUT_LAST  <= (word_cnt == WORD_LAST);
                            state     <= StOut;
                        end else begin
                            lat_cnt <= lat_cnt + 1'b1;
                        end
                    end
                    StOut: begin
                        if (OUT_READY) begin
                            OUT_VALID <= 1'b0;
                            OUT_LAST  <= 1'b0;
                            if (OUT_LAST) begin
                                CLR_BUF    <= buf_sel;
                                CLR_STROBE <= 1'b1;
                                hold_cnt   <= '0;
                                state      <= StClear;
                            end else begin
                                word_cnt <= word_cnt + 11'd1;
                                MEM_ADDR <= {buf_sel, word_cnt + 11'd1, 2'b00};
                                MEM_EN   <= 1'b1;
                                state    <= StIssue;
                            end
                        end
                    end
                    StClear: begin
                        if (hold_cnt == HOLD_LAST) begin
                            CLR_STROBE <= 1'b0;
                            RESULT     <= RES_OK;
                            DONE       <= 1'b1;
                            state      <= StFin;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    StFin: begin
                        BUSY  <= 1'b0;
                        state <= StIdle;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rd_readout_ctrl.sv
// Scoreboard bench for rd_readout_ctrl: stimulus pushes expected addresses,
// stream words and completion records; a negedge monitor pops and compares.
module tb_rd_readout_ctrl;

    localparam int unsigned NW   = 8;
    localparam int unsigned LAT  = 3;
    localparam int unsigned TMO  = 4096;
    localparam int unsigned HOLD = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [1:0]  BUF_RNUM;
    logic        ABORT;
    logic [3:0]  RD_BUF_FULL;
    logic [3:0]  RD_BUF_BUSY;
    logic [3:0]  RD_PAR_ERR;
    logic [14:0] MEM_ADDR;
    logic        MEM_EN;
    logic [31:0] MEM_DATA;
    logic [31:0] OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic        OUT_LAST;
    logic [1:0]  CLR_BUF;
    logic        CLR_STROBE;
    logic        BUSY;
    logic        DONE;
    logic [1:0]  RESULT;
    logic        PARITY_FLAG;

    rd_readout_ctrl #(
        .NWORDS  (NW),
        .MEM_LAT (LAT),
        .BUSY_TMO(TMO),
        .CLR_HOLD(HOLD)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START),
        .BUF_RNUM   (BUF_RNUM),
        .ABORT      (ABORT),
        .RD_BUF_FULL(RD_BUF_FULL),
        .RD_BUF_BUSY(RD_BUF_BUSY),
        .RD_PAR_ERR (RD_PAR_ERR),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_EN     (MEM_EN),
        .MEM_DATA   (MEM_DATA),
        .OUT_DATA   (OUT_DATA),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .OUT_LAST   (OUT_LAST),
        .CLR_BUF    (CLR_BUF),
        .CLR_STROBE (CLR_STROBE),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .RESULT     (RESULT),
        .PARITY_FLAG(PARITY_FLAG)
    );

    always #5 CLK = ~CLK;

    // Memory contents: a fixed pattern derived from the byte address.
    function automatic logic [31:0] mem_word(input logic [14:0] a);
        return {a, 17'h0} ^ {17'h0, a} ^ 32'h1234_5678;
    endfunction

    // Memory model with LAT cycles of read latency; idle slots carry junk.
    logic [31:0] pipe [LAT];
    always @(posedge CLK) begin
        pipe[0] <= MEM_EN ? mem_word(MEM_ADDR) : 32'hDEAD_BEEF;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign MEM_DATA = pipe[LAT-1];

    logic [57:0] outs;
    assign outs = {MEM_ADDR, MEM_EN, OUT_DATA, OUT_VALID, OUT_LAST, CLR_BUF, CLR_STROBE,
                   BUSY, DONE, RESULT, PARITY_FLAG};

    typedef struct {
        logic [1:0] result;
        logic       parity;
        int         nclr;
        logic [1:0] clr_buf;
        int         left;
    } done_t;

    logic [14:0] addr_q [$];
    logic [32:0] data_q [$];
    done_t       done_q [$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic note_fail(input string name, input logic [63:0] act);
        n_chk++;
        $display("FAIL %s: got %0h with nothing expected (t=%0t)", name, act, $time);
    endtask

    // Monitor
    int clr_cnt = 0;
    always @(negedge CLK) begin
        done_t d;
        if (RST) begin
            clr_cnt = 0;
        end else begin
            if (MEM_EN) begin
                if (addr_q.size() == 0) note_fail("mem_en_unexpected", 64'(MEM_ADDR));
                else chk("mem_addr", 64'(MEM_ADDR), 64'(addr_q.pop_front()));
            end
            if (OUT_VALID) begin
                if (data_q.size() == 0) begin
                    note_fail("out_valid_unexpected", 64'(OUT_DATA));
                end else begin
                    chk("out_data", 64'(OUT_DATA), 64'(data_q[0][31:0]));
                    chk("out_last", 64'(OUT_LAST), 64'(data_q[0][32]));
                    if (OUT_READY) void'(data_q.pop_front());
                end
            end
            if (CLR_STROBE) begin
                clr_cnt++;
                if (done_q.size() != 0) chk("clr_buf", 64'(CLR_BUF), 64'(done_q[0].clr_buf));
            end
            if (DONE) begin
                if (done_q.size() == 0) begin
                    note_fail("done_unexpected", 64'(RESULT));
                end else begin
                    d = done_q.pop_front();
                    chk("result", 64'(RESULT), 64'(d.result));
                    chk("parity_flag", 64'(PARITY_FLAG), 64'(d.parity));
                    chk("clr_cycles", 64'(clr_cnt), 64'(d.nclr));
                    chk("words_left", 64'(data_q.size()), 64'(d.left));
                    chk("reads_left", 64'(addr_q.size()), 64'd0);
                end
                data_q.delete();
                addr_q.delete();
                clr_cnt = 0;
            end
        end
    end

    task automatic expect_read(input logic [1:0] b, input int n_issue, input int n_data);
        for (int i = 0; i < n_issue; i++) begin
            logic [14:0] a;
            a = {b, 11'(i), 2'b00};
            addr_q.push_back(a);
            if (i < n_data) data_q.push_back({(i == NW - 1), mem_word(a)});
        end
    endtask

    task automatic expect_done(input logic [1:0] res, input logic par, input int nclr,
                               input logic [1:0] cb, input int left);
        done_t d;
        d.result = res; d.parity = par; d.nclr = nclr; d.clr_buf = cb; d.left = left;
        done_q.push_back(d);
    endtask

    task automatic start(input logic [1:0] b);
        BUF_RNUM = b;
        START    = 1'b1;
        @(posedge CLK); #1;
        START    = 1'b0;
    endtask

    // Returns n = index of the cycle (after START was taken) where DONE is seen.
    task automatic run(input int mode, input int abort_word, input int full_at,
                       input logic [3:0] full_val, input int again_at, input int max_cyc,
                       output int n);
        n = 1;
        while (n <= max_cyc && !DONE) begin
            OUT_READY = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            ABORT     = 1'b0;
            START     = (n == again_at);
            if (n == again_at) BUF_RNUM = 2'd3;
            if (abort_word >= 0 && OUT_VALID && int'(MEM_ADDR[12:2]) == abort_word) begin
                ABORT     = 1'b1;
                OUT_READY = 1'b0;
            end
            if (n == full_at) begin
                RD_BUF_FULL = full_val;
                RD_BUF_BUSY = 4'b0000;
            end
            @(posedge CLK); #1;
            n++;
        end
        START     = 1'b0;
        ABORT     = 1'b0;
        OUT_READY = 1'b1;
    endtask

    task automatic finish_run(input string name);
        @(posedge CLK); #1;
        chk({name, "_busy_clear"}, 64'(BUSY), 64'd0);
        chk({name, "_done_seen"}, 64'(done_q.size()), 64'd0);
        done_q.delete();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        RST = 1'b1; START = 1'b0; BUF_RNUM = 2'd0; ABORT = 1'b0; OUT_READY = 1'b1;
        RD_BUF_FULL = 4'b0; RD_BUF_BUSY = 4'b0; RD_PAR_ERR = 4'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_outputs", 64'(outs), 64'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // Empty buffer: no memory access, no clear.
        RD_PAR_ERR = 4'b1000;
        expect_done(2'd1, 1'b1, 0, 2'd0, 0);
        start(2'd3);
        chk("busy_after_start", 64'(BUSY), 64'd1);
        run(0, -1, -1, 4'b0, -1, 20, n);
        chk("empty_latency", 64'(n), 64'd2);
        finish_run("empty");

        // Full buffer 2, READY held high.
        RD_PAR_ERR  = 4'b0100;
        RD_BUF_FULL = 4'b0100;
        expect_read(2'd2, NW, NW);
        expect_done(2'd0, 1'b1, HOLD, 2'd2, 0);
        start(2'd2);
        run(0, -1, -1, 4'b0, -1, 500, n);
        chk("full_latency", 64'(n), 64'd46);
        finish_run("full");

        // Buffer 0 busy, becomes full after 100 cycles; stray START ignored.
        RD_PAR_ERR  = 4'b0000;
        RD_BUF_FULL = 4'b0000;
        RD_BUF_BUSY = 4'b0001;
        expect_read(2'd0, NW, NW);
        expect_done(2'd0, 1'b0, HOLD, 2'd0, 0);
        start(2'd0);
        run(0, -1, 100, 4'b0001, 50, 500, n);
        chk("wait_full_latency", 64'(n), 64'd145);
        finish_run("wait_full");

        // Buffer 1 stays busy: timeout.
        RD_BUF_FULL = 4'b0000;
        RD_BUF_BUSY = 4'b0010;
        expect_done(2'd2, 1'b0, 0, 2'd0, 0);
        start(2'd1);
        run(0, -1, -1, 4'b0, -1, 5000, n);
        chk("timeout_latency", 64'(n), 64'd4098);
        finish_run("timeout");

        // Random READY back-pressure on buffer 1.
        RD_BUF_BUSY = 4'b0000;
        RD_BUF_FULL = 4'b0010;
        expect_read(2'd1, NW, NW);
        expect_done(2'd0, 1'b0, HOLD, 2'd1, 0);
        start(2'd1);
        run(1, -1, -1, 4'b0, -1, 2000, n);
        chk("stall_done_in_time", 64'(n <= 2000), 64'd1);
        finish_run("stall");

        // Abort while word 5 is presented.
        RD_BUF_FULL = 4'b0100;
        expect_read(2'd2, 6, 6);
        expect_done(2'd3, 1'b0, 0, 2'd0, 1);
        start(2'd2);
        run(0, 5, -1, 4'b0, -1, 500, n);
        chk("abort_latency", 64'(n), 64'd32);
        finish_run("abort");

        // Asynchronous reset in the middle of the clear strobe.
        RD_BUF_FULL = 4'b1000;
        expect_read(2'd3, NW, NW);
        start(2'd3);
        k = 0;
        while (!CLR_STROBE && k < 200) begin
            @(posedge CLK); #1;
            k++;
        end
        chk("clr_reached", 64'(k < 200), 64'd1);
        @(posedge CLK); #1;
        chk("clr_strobe_mid_clear", 64'(CLR_STROBE), 64'd1);
        #2 RST = 1'b1;
        #1;
        chk("rst_clr_strobe_drop", 64'(CLR_STROBE), 64'd0);
        chk("rst_all_outputs", 64'(outs), 64'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("rst_reads_consumed", 64'(addr_q.size()), 64'd0);
        chk("rst_words_consumed", 64'(data_q.size()), 64'd0);
        addr_q.delete();
        data_q.delete();
        RD_BUF_FULL = 4'b0000;
        @(posedge CLK); #1;

        // Controller usable again after reset.
        expect_done(2'd1, 1'b0, 0, 2'd0, 0);
        start(2'd3);
        run(0, -1, -1, 4'b0, -1, 20, n);
        chk("post_rst_latency", 64'(n), 64'd2);
        finish_run("post_rst");

        repeat (2) @(posedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
